// File: rtl/rx_medida_serial_pkg.sv
// Shared encodings and character constants for the tank-level telemetry receiver.
package rx_medida_serial_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    INICIO = 2'd1,
    DADOS  = 2'd2,
    PARADA = 2'd3
  } uart_estado_t;

  typedef enum logic [1:0] {
    ESPERA_D0  = 2'd0,
    ESPERA_D1  = 2'd1,
    ESPERA_D2  = 2'd2,
    ESPERA_FIM = 2'd3
  } parser_estado_t;

  localparam logic [7:0] ASC_ZERO    = 8'h30;
  localparam logic [7:0] ASC_FIM     = 8'h23;
  localparam logic [7:0] ASC_DIG_MAX = 8'h3F;

  // The transmitter encodes nibbles A..F as 0x3A..0x3F, not as ASCII letters.
  function automatic logic eh_digito(input logic [7:0] c);
    return (c >= ASC_ZERO) && (c <= ASC_DIG_MAX);
  endfunction

endpackage

// File: rtl/rx_medida_serial_if.sv
// Serial input plus decoded-measurement outputs of the telemetry receiver.
interface rx_medida_serial_if;
  logic        RX;
  logic [11:0] medida;
  logic        medida_valida;
  logic        erro_quadro;
  logic [3:0]  db_estado;

  modport master (
    input  RX,
    output medida, medida_valida, erro_quadro, db_estado
  );

  modport slave (
    output RX,
    input  medida, medida_valida, erro_quadro, db_estado
  );
endinterface

// File: rtl/rx_serial_8N1.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
module rx_serial_8N1
  import rx_medida_serial_pkg::*;
#(
  parameter int TICKS_BIT = 434
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         rx,
  output logic [7:0]   byte_dado,
  output logic         byte_ok,
  output logic         erro_parada,
  output uart_estado_t estado
);

  localparam int CW = $clog2(TICKS_BIT) + 1;
  localparam logic [CW-1:0] MEIO_FIM = CW'(TICKS_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_FIM  = CW'(TICKS_BIT - 1);

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  uart_estado_t  estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    shift_q, shift_d;
  logic          espera_alto_q, espera_alto_d;
  logic          byte_ok_q, byte_ok_d;
  logic          erro_q, erro_d;

  always_comb begin
    estado_d      = estado_q;
    cnt_d         = cnt_q;
    nbit_d        = nbit_q;
    shift_d       = shift_q;
    espera_alto_d = espera_alto_q;
    byte_ok_d     = 1'b0;
    erro_d        = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (rx_prev_q && !rx_sync_q) begin
          estado_d = INICIO;
          cnt_d    = '0;
        end
      end
      INICIO: begin
        if (cnt_q == MEIO_FIM) begin
          cnt_d  = '0;
          nbit_d = '0;
          // A start bit already back high at mid-bit is noise, not a character.
          estado_d = rx_sync_q ? OCIOSO : DADOS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DADOS: begin
        if (cnt_q == BIT_FIM) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          nbit_d  = nbit_q + 3'd1;
          if (nbit_q == 3'd7) estado_d = PARADA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARADA: begin
        if (espera_alto_q) begin
          if (rx_sync_q) begin
            espera_alto_d = 1'b0;
            estado_d      = OCIOSO;
          end
        end else if (cnt_q == BIT_FIM) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_ok_d = 1'b1;
            estado_d  = OCIOSO;
          end else begin
            // Line still low after a bad stop: hold off until it idles high.
            erro_d        = 1'b1;
            espera_alto_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      estado_q      <= OCIOSO;
      cnt_q         <= '0;
      nbit_q        <= '0;
      shift_q       <= '0;
      espera_alto_q <= 1'b0;
      byte_ok_q     <= 1'b0;
      erro_q        <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      estado_q      <= estado_d;
      cnt_q         <= cnt_d;
      nbit_q        <= nbit_d;
      shift_q       <= shift_d;
      espera_alto_q <= espera_alto_d;
      byte_ok_q     <= byte_ok_d;
      erro_q        <= erro_d;
    end
  end

  assign byte_dado   = shift_q;
  assign byte_ok     = byte_ok_q;
  assign erro_parada = erro_q;
  assign estado      = estado_q;

endmodule

// File: rtl/rx_medida_serial.sv
// Telemetry receiver: rebuilds 12-bit distance from "ddd#" ASCII frames.
// Optional inter-character timeout enabled by defining RX_MEDIDA_TIMEOUT_EN.
module rx_medida_serial
  import rx_medida_serial_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  rx_medida_serial_if.master bus
);

  localparam int TICKS_BIT = CLK_FREQ / BAUD;

  logic [7:0]   byte_dado;
  logic         byte_ok;
  logic         erro_parada;
  uart_estado_t estado_uart;

  rx_serial_8N1 #(
    .TICKS_BIT(TICKS_BIT)
  ) u_uart (
    .clock      (clock),
    .reset      (reset),
    .rx         (bus.RX),
    .byte_dado  (byte_dado),
    .byte_ok    (byte_ok),
    .erro_parada(erro_parada),
    .estado     (estado_uart)
  );

  parser_estado_t parser_q, parser_d;
  logic [11:0]    shadow_q, shadow_d;
  logic [11:0]    medida_q, medida_d;
  logic           valida_q, valida_d;
  logic           erro_q, erro_d;

`ifdef RX_MEDIDA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] gap_q, gap_d;
  logic          timeout;

  assign timeout = (parser_q != ESPERA_D0) && (estado_uart == OCIOSO) &&
                   (gap_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    parser_d = parser_q;
    shadow_d = shadow_q;
    medida_d = medida_q;
    valida_d = 1'b0;
    erro_d   = 1'b0;
    if (erro_parada) begin
      erro_d   = 1'b1;
      parser_d = ESPERA_D0;
    end else if (byte_ok) begin
      if (parser_q == ESPERA_FIM) begin
        if (byte_dado == ASC_FIM) begin
          medida_d = shadow_q;
          valida_d = 1'b1;
        end else begin
          erro_d = 1'b1;
        end
        parser_d = ESPERA_D0;
      end else if (eh_digito(byte_dado)) begin
        case (parser_q)
          ESPERA_D0: shadow_d[11:8] = byte_dado[3:0];
          ESPERA_D1: shadow_d[7:4]  = byte_dado[3:0];
          default:   shadow_d[3:0]  = byte_dado[3:0];
        endcase
        parser_d = parser_estado_t'(parser_q + 2'd1);
      end else begin
        // Stray '#' or non-digit: drop the partial frame and resynchronise.
        erro_d   = 1'b1;
        parser_d = ESPERA_D0;
      end
    end
`ifdef RX_MEDIDA_TIMEOUT_EN
    else if (timeout) begin
      erro_d   = 1'b1;
      parser_d = ESPERA_D0;
      shadow_d = '0;
    end
`endif
  end

`ifdef RX_MEDIDA_TIMEOUT_EN
  // Gap only accrues while a frame is open and the line is idle.
  always_comb begin
    gap_d = gap_q;
    if (byte_ok || timeout || parser_q == ESPERA_D0) begin
      gap_d = '0;
    end else if (estado_uart == OCIOSO) begin
      gap_d = gap_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parser_q <= ESPERA_D0;
      shadow_q <= '0;
      medida_q <= '0;
      valida_q <= 1'b0;
      erro_q   <= 1'b0;
`ifdef RX_MEDIDA_TIMEOUT_EN
      gap_q    <= '0;
`endif
    end else begin
      parser_q <= parser_d;
      shadow_q <= shadow_d;
      medida_q <= medida_d;
      valida_q <= valida_d;
      erro_q   <= erro_d;
`ifdef RX_MEDIDA_TIMEOUT_EN
      gap_q    <= gap_d;
`endif
    end
  end

  assign bus.medida        = medida_q;
  assign bus.medida_valida = valida_q;
  assign bus.erro_quadro   = erro_q;
  assign bus.db_estado     = {estado_uart, parser_q};

endmodule

// File: tb/tb_rx_medida_serial.sv
// Self-checking bench for rx_medida_serial: directed frames plus randomized frames vs a model.
module tb_rx_medida_serial;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int T        = CLK_FREQ / BAUD;
  localparam int TIMEOUT  = 1000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rx_medida_serial_if bus();

  rx_medida_serial #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Observed pulses, collected by the monitor.
  logic [11:0] got_q[$];
  int          err_seen = 0;
  bit          prev_valida = 0;

  // Reference model: nibbles of the open frame, expected words and errors.
  logic [3:0]  mdl_nib[$];
  logic [11:0] exp_q[$];
  int          exp_err = 0;
  logic [11:0] mdl_medida = '0;

  always @(negedge clock) begin
    if (reset) begin
      prev_valida = 0;
    end else begin
      if (bus.medida_valida) got_q.push_back(bus.medida);
      if (bus.erro_quadro) err_seen++;
      if (bus.medida_valida || bus.erro_quadro) begin
        vectors++;
        if (bus.medida_valida && bus.erro_quadro) begin
          miscompares++;
          $display("FAIL pulso_simultaneo: valida=%b erro=%b, required never both", bus.medida_valida, bus.erro_quadro);
        end else if (bus.medida_valida && prev_valida) begin
          miscompares++;
          $display("FAIL largura_valida: valida high 2 cycles, required 1 cycle");
        end
      end
      prev_valida = bus.medida_valida;
    end
  end

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog: run exceeded cycle budget, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void mdl_char(input logic [7:0] c, input bit stop_ok);
    logic [11:0] w;
    if (!stop_ok) begin
      exp_err++;
      mdl_nib.delete();
    end else if (mdl_nib.size() < 3) begin
      if (c >= 8'h30 && c <= 8'h3F) begin
        mdl_nib.push_back(c[3:0]);
      end else begin
        exp_err++;
        mdl_nib.delete();
      end
    end else begin
      if (c == 8'h23) begin
        w = {mdl_nib[0], mdl_nib[1], mdl_nib[2]};
        exp_q.push_back(w);
        mdl_medida = w;
      end else begin
        exp_err++;
      end
      mdl_nib.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    logic [9:0] quadro;
    quadro = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.RX = quadro[i];
      repeat (T) @(negedge clock);
    end
    bus.RX = 1'b1;
    if (!stop_ok) repeat (T) @(negedge clock);
    repeat (gap) @(negedge clock);
    mdl_char(b, stop_ok);
    $display("byte 0x%02h stop=%0d gap=%0d", b, stop_ok, gap);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    @(posedge clock);
    #1;
    got_q.delete();
    err_seen = 0;
    exp_q.delete();
    exp_err = 0;
  endtask

  task automatic test_reset();
    bus.RX = 1'b1;
    reset  = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if (bus.medida !== 12'h000) begin miscompares++; $display("FAIL reset_medida: got %h required 000", bus.medida); end
    vectors++;
    if (bus.medida_valida !== 1'b0) begin miscompares++; $display("FAIL reset_valida: got %b required 0", bus.medida_valida); end
    vectors++;
    if (bus.erro_quadro !== 1'b0) begin miscompares++; $display("FAIL reset_erro: got %b required 0", bus.erro_quadro); end
    vectors++;
    if (bus.db_estado !== 4'h0) begin miscompares++; $display("FAIL reset_estado: got %h required 0", bus.db_estado); end
    $display("reset checked");
  endtask

  task automatic test_frame_basico();
    clear_obs();
    send_byte(8'h31, 1, 0); send_byte(8'h32, 1, 0);
    send_byte(8'h33, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (got_q.size() != 1) begin miscompares++; $display("FAIL basico_pulsos: got %0d required 1", got_q.size()); end
    vectors++;
    if (bus.medida !== 12'h123) begin miscompares++; $display("FAIL basico_medida: got %h required 123", bus.medida); end
    vectors++;
    if (err_seen != 0) begin miscompares++; $display("FAIL basico_erro: got %0d required 0", err_seen); end
    $display("frame basico medida=%h", bus.medida);
  endtask

  task automatic test_back_to_back();
    logic [11:0] g0, g1;
    clear_obs();
    send_byte(8'h30, 1, 0); send_byte(8'h3F, 1, 0);
    send_byte(8'h3A, 1, 0); send_byte(8'h23, 1, 0);
    send_byte(8'h39, 1, 0); send_byte(8'h38, 1, 0);
    send_byte(8'h37, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    g0 = (got_q.size() > 0) ? got_q[0] : 12'hxxx;
    g1 = (got_q.size() > 1) ? got_q[1] : 12'hxxx;
    vectors++;
    if (got_q.size() != 2) begin miscompares++; $display("FAIL b2b_pulsos: got %0d required 2", got_q.size()); end
    vectors++;
    if (g0 !== 12'h0FA) begin miscompares++; $display("FAIL b2b_primeiro: got %h required 0fa", g0); end
    vectors++;
    if (g1 !== 12'h987) begin miscompares++; $display("FAIL b2b_segundo: got %h required 987", g1); end
    vectors++;
    if (err_seen != 0) begin miscompares++; $display("FAIL b2b_erro: got %0d required 0", err_seen); end
    $display("frames back-to-back medida=%h", bus.medida);
  endtask

  task automatic test_resync();
    clear_obs();
    send_byte(8'h31, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (err_seen != 1) begin miscompares++; $display("FAIL resync_erro: got %0d required 1", err_seen); end
    vectors++;
    if (bus.medida !== 12'h987) begin miscompares++; $display("FAIL resync_mantem: got %h required 987", bus.medida); end
    send_byte(8'h34, 1, 0); send_byte(8'h35, 1, 0);
    send_byte(8'h36, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (bus.medida !== 12'h456 || got_q.size() != 1) begin
      miscompares++; $display("FAIL resync_medida: got %h (%0d pulses) required 456 (1)", bus.medida, got_q.size());
    end
    $display("resync medida=%h", bus.medida);
  endtask

  task automatic test_erro_parada();
    clear_obs();
    send_byte(8'h31, 1, 0); send_byte(8'h32, 0, 0);
    settle(2);
    vectors++;
    if (err_seen != 1) begin miscompares++; $display("FAIL parada_erro: got %0d required 1", err_seen); end
    vectors++;
    if (bus.db_estado[1:0] !== 2'd0) begin miscompares++; $display("FAIL parada_parser: got %0d required 0", bus.db_estado[1:0]); end
    send_byte(8'h37, 1, 0); send_byte(8'h38, 1, 0);
    send_byte(8'h39, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (bus.medida !== 12'h789 || got_q.size() != 1) begin
      miscompares++; $display("FAIL parada_seguinte: got %h (%0d pulses) required 789 (1)", bus.medida, got_q.size());
    end
    $display("stop error recovered medida=%h", bus.medida);
  endtask

  task automatic test_glitch();
    clear_obs();
    @(negedge clock);
    bus.RX = 1'b0;
    repeat (2) @(negedge clock);
    bus.RX = 1'b1;
    settle(30);
    vectors++;
    if (err_seen != 0 || got_q.size() != 0) begin
      miscompares++; $display("FAIL glitch: got %0d errors %0d pulses required 0 0", err_seen, got_q.size());
    end
    vectors++;
    if (bus.db_estado !== 4'h0) begin miscompares++; $display("FAIL glitch_estado: got %h required 0", bus.db_estado); end
    $display("glitch ignored");
  endtask

  task automatic test_reset_meio();
    send_byte(8'h31, 1, 0); send_byte(8'h32, 1, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mdl_nib.delete();
    clear_obs();
    vectors++;
    if (bus.medida !== 12'h000 || bus.db_estado !== 4'h0) begin
      miscompares++; $display("FAIL reset_meio: got medida %h estado %h required 000 0", bus.medida, bus.db_estado);
    end
    send_byte(8'h41, 1, 0); send_byte(8'h42, 1, 0);
    send_byte(8'h43, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (err_seen != 4 || got_q.size() != 0 || bus.medida !== 12'h000) begin
      miscompares++; $display("FAIL reset_rejeita: got %0d errors %0d pulses medida %h required 4 0 000", err_seen, got_q.size(), bus.medida);
    end
    send_byte(8'h3A, 1, 0); send_byte(8'h3B, 1, 0);
    send_byte(8'h3C, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (bus.medida !== 12'hABC) begin miscompares++; $display("FAIL reset_abc: got %h required abc", bus.medida); end
    $display("reset mid-frame medida=%h", bus.medida);
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'h31, 1, 0);
    settle(950);
    vectors++;
    if (err_seen != 0) begin miscompares++; $display("FAIL timeout_cedo: got %0d required 0", err_seen); end
    settle(550);
`ifdef RX_MEDIDA_TIMEOUT_EN
    vectors++;
    if (err_seen != 1 || bus.db_estado[1:0] !== 2'd0) begin
      miscompares++; $display("FAIL timeout_dispara: got %0d errors parser %0d required 1 0", err_seen, bus.db_estado[1:0]);
    end
    send_byte(8'h32, 1, 0); send_byte(8'h33, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (err_seen != 2 || got_q.size() != 0) begin
      miscompares++; $display("FAIL timeout_descarta: got %0d errors %0d pulses required 2 0", err_seen, got_q.size());
    end
`else
    vectors++;
    if (err_seen != 0 || bus.db_estado[1:0] !== 2'd1) begin
      miscompares++; $display("FAIL sem_timeout: got %0d errors parser %0d required 0 1", err_seen, bus.db_estado[1:0]);
    end
    send_byte(8'h32, 1, 0); send_byte(8'h33, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    vectors++;
    if (bus.medida !== 12'h123 || got_q.size() != 1) begin
      miscompares++; $display("FAIL sem_timeout_medida: got %h (%0d pulses) required 123 (1)", bus.medida, got_q.size());
    end
`endif
    $display("gap test medida=%h errors=%0d", bus.medida, err_seen);
    mdl_nib.delete();
  endtask

  task automatic test_aleatorio();
    logic [7:0] c;
    int r, nmin;
    clear_obs();
    mdl_nib.delete();
    send_byte(8'h3F, 1, 0); send_byte(8'h3F, 1, 0);
    send_byte(8'h3F, 1, 0); send_byte(8'h23, 1, 0);
    settle(4);
    for (int k = 0; k < 25; k++) begin
      clear_obs();
      for (int j = 0; j < 4; j++) begin
        c = (j == 3) ? 8'h23 : (8'h30 + 8'($urandom_range(0, 15)));
        r = $urandom_range(0, 99);
        if (r < 8) begin
          send_byte(c, 0, $urandom_range(0, 4));
        end else begin
          if (r < 16) c = 8'($urandom_range(0, 255));
          send_byte(c, 1, $urandom_range(0, 4));
        end
      end
      settle(4);
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL aleatorio_pulsos[%0d]: got %0d required %0d", k, got_q.size(), exp_q.size());
      end
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL aleatorio_valor[%0d]: got %h required %h", k, got_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (err_seen != exp_err) begin
        miscompares++; $display("FAIL aleatorio_erros[%0d]: got %0d required %0d", k, err_seen, exp_err);
      end
      vectors++;
      if (bus.medida !== mdl_medida) begin
        miscompares++; $display("FAIL aleatorio_medida[%0d]: got %h required %h", k, bus.medida, mdl_medida);
      end
      $display("random frame %0d medida=%h errors=%0d", k, bus.medida, err_seen);
    end
  endtask

  initial begin
    bus.RX = 1'b1;
    test_reset();
    test_frame_basico();
    test_back_to_back();
    test_resync();
    test_erro_parada();
    test_glitch();
    test_reset_meio();
    test_timeout();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
